uart_rx_deserializer: RTL

Receive-side serial-to-parallel stage that consumes the `rx` line of the UART interface and delivers complete characters to the receive monitor/scoreboard path. It synchronises `rx`, detects start bits, samples each bit at its centre, checks parity and stop bit, and presents each character through a valid/ready handshake with a single-entry holding register. An overrun is flagged when a new character completes while the previous one is still unaccepted.

---
 rtl/uart_rx_deserializer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronises rx, samples each bit at its centre,
// checks parity/stop and hands characters out through a one-entry valid/ready register.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  framing_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_q;
  logic                    rx_meta_q, rx_s_q, rx_prev_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    perr_frame_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    valid_q, perr_q, ferr_q, ovr_q;

  logic half_end_d, bit_end_d, complete_d, load_d;

  assign half_end_d = (cnt_q == CNT_W'(CLKS_PER_BIT/2 - 1));
  assign bit_end_d  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  // The frame completes on the stop-bit sample itself, so the holding register loads in that cycle.
  assign complete_d = (state_q == STOP) && bit_end_d;
  assign load_d     = complete_d && (!valid_q || data_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      perr_frame_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      cnt_q     <= cnt_q + 1'b1;
      ovr_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rx_prev_q && !rx_s_q) state_q <= START;
        end
        START: begin
          if (half_end_d) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            perr_frame_q <= 1'b0;
            state_q      <= rx_s_q ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bit_end_d) begin
            // LSB arrives first, so shifting in from the top leaves bit 0 at the bottom.
            shift_q <= {rx_s_q, shift_q[DATA_WIDTH-1:1]};
            cnt_q   <= '0;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IDX_W'(DATA_WIDTH - 1))
              state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_end_d) begin
            perr_frame_q <= (((^shift_q) ^ rx_s_q) != (PARITY_ODD != 0));
            cnt_q        <= '0;
            state_q      <= STOP;
          end
        end
        STOP: begin
          if (bit_end_d) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (load_d) begin
        data_q  <= shift_q;
        perr_q  <= perr_frame_q;
        ferr_q  <= !rx_s_q;
        valid_q <= 1'b1;
      end else begin
        if (complete_d) ovr_q <= 1'b1;
        if (valid_q && data_ready) valid_q <= 1'b0;
      end
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign parity_err  = perr_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != IDLE);

endmodule
